// File: rtl/mux_4by64_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4by64_arb
//  Description : Four-requester round-robin arbiter feeding a registered
//                WIDTH-bit output stage with valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_4by64_arb #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [WIDTH-1:0] data_3,
    output logic [3:0]       gnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    logic [1:0]       ptr_q,       ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [1:0]       out_src_q,   out_src_d;

    logic             load;
    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] win_data;
    logic [3:0]       grant;

    always_comb begin
        load      = !out_valid_q || out_ready;
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = ptr_q;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        case (win_idx)
            2'd0:    win_data = data_0;
            2'd1:    win_data = data_1;
            2'd2:    win_data = data_2;
            default: win_data = data_3;
        endcase

        grant = 4'b0000;
        if (rst_n && load && win_found) begin
            grant[win_idx] = 1'b1;
        end

        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load) begin
            if (win_found) begin
                out_valid_d = 1'b1;
                out_data_d  = win_data;
                out_src_d   = win_idx;
                ptr_d       = win_idx + 2'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign gnt       = grant;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
`default_nettype wire
